// File: rtl/serial_adder_64_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width, default width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SLICE_W       = 4;
    localparam int unsigned DEFAULT_WIDTH = 64;

endpackage

// File: rtl/serial_adder_64_if.sv
// Start/done handshake and operand/result bus of serial_adder_64.
// V is present only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_64_if #(
    parameter int unsigned WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] S;
    logic             Co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             V;

    modport master (output Start, A, B, Ci, input Busy, Done, S, Co, V);
    modport slave  (input Start, A, B, Ci, output Busy, Done, S, Co, V);
`else
    modport master (output Start, A, B, Ci, input Busy, Done, S, Co);
    modport slave  (input Start, A, B, Ci, output Busy, Done, S, Co);
`endif
endinterface

// File: rtl/serial_adder_64_fa4.sv
// Existing 4-bit adder slice driven one nibble per clock by serial_adder_64.
module FullAdder4Bit (
    input  logic       Ci,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Co
);
    logic [4:0] sum;

    always_comb begin
        sum = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};
    end

    assign S  = sum[3:0];
    assign Co = sum[4];
endmodule

// File: rtl/serial_adder_64.sv
// Multi-cycle adder: feeds FullAdder4Bit one nibble per clock, LS nibble first.
// Optional signed-overflow output V enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_64
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = SLICE_W
) (
    input  logic            Clk,
    input  logic            Rst,
    serial_adder_64_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_d;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH+SLICE-1:0] shift_in;

    FullAdder4Bit u_slice (
        .Ci (carry_q),
        .A  (a_q[SLICE-1:0]),
        .B  (b_q[SLICE-1:0]),
        .S  (slice_s),
        .Co (slice_co)
    );

    // New slice enters at the top; after NSLICE shifts the LS nibble sits at bit 0.
    always_comb begin
        shift_in = {slice_s, psum_q};
        psum_d   = shift_in[WIDTH+SLICE-1:SLICE];
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic v_q;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            v_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        carry_q <= bus.Ci;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        a_msb_q <= bus.A[WIDTH-1];
                        b_msb_q <= bus.B[WIDTH-1];
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    psum_q  <= psum_d;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        s_q     <= psum_d;
                        co_q    <= slice_co;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        v_q     <= (a_msb_q == b_msb_q) && (psum_d[WIDTH-1] != a_msb_q);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S    = s_q;
    assign bus.Co   = co_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.V    = v_q;
`endif

endmodule
